// File: rtl/fft_pkg.sv
// Shared definitions for the FFT source- and sink-side controllers:
// default frame length, controller state encoding and I/Q packing order.
package fft_pkg;

    localparam int FFT_LEN_DEF = 8192;

    // Nonzero: real part occupies the upper half of a packed {real,imag} word.
    localparam int IQ_REAL_HI = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } fft_state_e;

endpackage

// File: rtl/fft_source_ctrl.sv
// Accepts FFT output beats, checks frame framing and error codes, and
// forwards each in-frame beat to the result FIFO one cycle later.
module fft_source_ctrl
    import fft_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEF,
    parameter int DATA_W  = 16,
    localparam int IDX_W  = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                source_valid,
    input  logic                source_sop,
    input  logic                source_eop,
    input  logic [DATA_W-1:0]   source_real,
    input  logic [DATA_W-1:0]   source_imag,
    input  logic [5:0]          source_exp,
    input  logic [1:0]          source_error,
    output logic                source_ready,
    output logic                wr_fifo_en,
    output logic [2*DATA_W-1:0] wr_data,
    input  logic                wrfull,
    output logic [IDX_W-1:0]    bin_idx,
    output logic [5:0]          frame_exp,
    output logic                frame_done,
    output logic                frame_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LEN - 1);
    localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

    fft_state_e          state_r, state_n;
    logic [IDX_W-1:0]    cnt_r, cnt_n;
    logic                err_flag_r, err_flag_n;
    logic                accept_s;
    logic                beat_err_s;
    logic [2*DATA_W-1:0] packed_s;
    logic                wr_en_n;
    logic [2*DATA_W-1:0] wr_data_n;
    logic [IDX_W-1:0]    bin_n;
    logic [5:0]          exp_n;
    logic                done_n;
    logic                ferr_n;

    // Backpressure: DROP sinks everything, otherwise follow the FIFO.
    always_comb begin
        if (state_r == ST_DROP) begin
            source_ready = 1'b1;
        end else begin
            source_ready = ~wrfull;
        end
    end

    assign accept_s   = source_valid & source_ready;
    assign beat_err_s = (source_error != 2'b00);
    assign packed_s   = (IQ_REAL_HI != 0) ? {source_real, source_imag}
                                          : {source_imag, source_real};

    // Next-state, bin counter and registered-output computation.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        err_flag_n = err_flag_r;
        wr_en_n    = 1'b0;
        wr_data_n  = wr_data;
        bin_n      = bin_idx;
        exp_n      = frame_exp;
        done_n     = 1'b0;
        ferr_n     = 1'b0;
        if (accept_s && source_sop) begin
            // A sop always opens a fresh frame at index 0, aborting any open one.
            wr_en_n    = 1'b1;
            wr_data_n  = packed_s;
            bin_n      = '0;
            exp_n      = source_exp;
            err_flag_n = beat_err_s;
            if (source_eop) begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                if ((LAST_IDX == '0) && !beat_err_s && (state_r != ST_RECV)) begin
                    done_n = 1'b1;
                end else begin
                    ferr_n = 1'b1;
                end
            end else if (LAST_IDX == '0) begin
                state_n = ST_DROP;
                cnt_n   = '0;
                ferr_n  = 1'b1;
            end else begin
                state_n = ST_RECV;
                cnt_n   = CNT_ONE;
                ferr_n  = (state_r == ST_RECV);
            end
        end else if (accept_s) begin
            case (state_r)
                ST_IDLE: begin
                    ferr_n = 1'b1;
                end
                ST_RECV: begin
                    wr_en_n    = 1'b1;
                    wr_data_n  = packed_s;
                    bin_n      = cnt_r;
                    err_flag_n = err_flag_r | beat_err_s;
                    if (source_eop) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                        if ((cnt_r == LAST_IDX) && !(err_flag_r | beat_err_s)) begin
                            done_n = 1'b1;
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end else if (cnt_r == LAST_IDX) begin
                        state_n = ST_DROP;
                        cnt_n   = '0;
                        ferr_n  = 1'b1;
                    end else begin
                        cnt_n = cnt_r + CNT_ONE;
                    end
                end
                ST_DROP: begin
                    if (source_eop) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DROP;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            err_flag_r <= 1'b0;
            wr_fifo_en <= 1'b0;
            wr_data    <= '0;
            bin_idx    <= '0;
            frame_exp  <= 6'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            err_flag_r <= err_flag_n;
            wr_fifo_en <= wr_en_n;
            wr_data    <= wr_data_n;
            bin_idx    <= bin_n;
            frame_exp  <= exp_n;
            frame_done <= done_n;
            frame_err  <= ferr_n;
        end
    end

endmodule

// File: doc/fft_source_ctrl.md
FFT_SOURCE_CTRL -- requirements
Module: fft_source_ctrl

Interface
REQ-001 SHALL have parameter FFT_LEN, default 8192, meaning points per FFT frame (power of two).
REQ-002 SHALL have parameter DATA_W, default 16, meaning width of source_real and source_imag.
REQ-003 SHALL have port clk  in  1  system clock; one clock only, all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port source_valid  in  1  FFT output beat valid.
REQ-006 SHALL have port source_sop  in  1  first beat of frame.
REQ-007 SHALL have port source_eop  in  1  last beat of frame.
REQ-008 SHALL have port source_real  in  DATA_W  real part, signed.
REQ-009 SHALL have port source_imag  in  DATA_W  imag part, signed.
REQ-010 SHALL have port source_exp  in  6  block exponent, signed.
REQ-011 SHALL have port source_error  in  2  FFT error code; nonzero means error.
REQ-012 SHALL have port source_ready  out  1  backpressure to FFT.
REQ-013 SHALL have port wr_fifo_en  out  1  result FIFO write strobe.
REQ-014 SHALL have port wr_data  out  2*DATA_W  {real,imag}.
REQ-015 SHALL have port wrfull  in  1  result FIFO full.
REQ-016 SHALL have port bin_idx  out  log2(FFT_LEN)  bin number of current wr_data.
REQ-017 SHALL have port frame_exp  out  6  exponent latched at sop.
REQ-018 SHALL have port frame_done  out  1  one-cycle pulse, good frame complete.
REQ-019 SHALL have port frame_err  out  1  one-cycle pulse, framing or FFT error.

Function
REQ-020 SHALL treat a beat as accepted only when source_valid && source_ready on the same edge.
REQ-021 SHALL drive source_ready = ~wrfull in IDLE and RECV, and 1 in DROP (zero ready latency).
REQ-022 SHALL implement states IDLE, RECV and DROP.
REQ-023 IDLE: accepted beat with sop -> RECV, bin counter = 1, frame_exp <= source_exp; accepted beat without sop -> discarded, frame_err pulse, stay IDLE.
REQ-024 RECV: each accepted beat increments the bin counter; the counter wraps at FFT_LEN.
REQ-025 RECV: eop on beat index FFT_LEN-1 with no error seen -> frame_done pulse, then IDLE.
REQ-026 RECV: eop on any other index -> frame_err pulse, then IDLE.
REQ-027 RECV: beat index FFT_LEN-1 without eop -> frame_err pulse, then DROP.
REQ-028 RECV: sop on a beat -> frame_err pulse for the aborted frame; that beat restarts a new frame at index 0 with a new exponent.
REQ-029 Any accepted beat with source_error != 0 SHALL set a per-frame error flag; at frame end frame_err pulses instead of frame_done.
REQ-030 DROP: accepted beats are discarded; eop -> IDLE; sop -> RECV as in REQ-023.
REQ-031 Every accepted beat in IDLE-with-sop or RECV SHALL produce wr_fifo_en high exactly one cycle later, with wr_data = {real,imag} and bin_idx of that beat (1-cycle registered latency).
REQ-032 frame_done and frame_err SHALL assert in the same cycle as the wr_fifo_en of the eop beat; they are never both high.
REQ-033 A single sop+eop beat SHALL be handled as a short frame: write, frame_err, IDLE (unless FFT_LEN==1).

Reset
REQ-034 On rst: state IDLE, counter 0, error flag 0, wr_fifo_en 0, wr_data 0, bin_idx 0, frame_exp 0, frame_done 0, frame_err 0; source_ready = ~wrfull.
REQ-035 rst mid-frame SHALL abandon the frame with no pulse; the next accepted non-sop beat is handled per REQ-023.

Structure
REQ-036 FFT_LEN default, state encoding and the {real,imag} packing order SHALL live in shared package fft_pkg, also used by the sink-side controller.
REQ-037 No sub-module is required; bin counter and FSM stay inline.

Verification
REQ-038 FFT_LEN=16: clean 16-beat frame, exp=-3 -> 16 writes, bin_idx 0..15, frame_done at bin 15, frame_exp=-3.
REQ-039 wrfull held for 3 cycles mid-frame -> source_ready low for those 3 cycles, no beats lost, frame_done still asserted.
REQ-040 eop on beat 9 -> 10 writes, frame_err, next sop frame completes normally.
REQ-041 sop on beat 5 of a frame -> frame_err, bin_idx restarts at 0, following 16 beats end with frame_done.
REQ-042 source_error=2'b01 on beat 3 -> 16 writes, frame_err at eop, no frame_done.
REQ-043 rst asserted at beat 7, then beats without sop -> no writes, frame_err pulse per beat until sop.
